vga_mem_writer: RTL and testbench



---
 rtl/vga_mem_pkg.sv | 25 ++
 rtl/vga_pxl_packer.sv | 70 +++++++
 rtl/vga_mem_writer.sv | 186 ++++++++++++++++++
 tb/tb_vga_mem_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// -----------------------------------------------------------------------------
// vga_mem_pkg
// Shared constants and types for the VGA frame-memory write path.
//   VGA_RAM_WIDTH / VGA_RAM_DEPTH / VGA_PXL_WIDTH : default geometry
//   VGA_PXLS_PER_WORD, VGA_ADDR_WIDTH             : derived values
//   vga_mem_wr_state_t                            : writer FSM states
// The CLEAR state is only reachable when VGA_MEM_WRITER_CLEAR_EN is defined.
// -----------------------------------------------------------------------------
package vga_mem_pkg;

    localparam int VGA_RAM_WIDTH     = 72;
    localparam int VGA_RAM_DEPTH     = 480;
    localparam int VGA_PXL_WIDTH     = 12;
    localparam int VGA_PXLS_PER_WORD = VGA_RAM_WIDTH / VGA_PXL_WIDTH;
    localparam int VGA_ADDR_WIDTH    = $clog2(VGA_RAM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        DONE,
        CLEAR
    } vga_mem_wr_state_t;

endpackage

// File: rtl/vga_pxl_packer.sv
// -----------------------------------------------------------------------------
// vga_pxl_packer
// Collects pixels into one memory word. Pixel k of a word lands in bits
// [k*PXL_WIDTH +: PXL_WIDTH] (pixel 0 in the LSBs).
// Ports:
//   clk_in, rstn_in : clock, asynchronous active-low reset
//   clear           : drop any partial word, pixel count back to 0
//   load            : accept pxl_data into the next slot
//   pxl_data        : incoming pixel
//   packed_word     : current word with pxl_data merged into the slot being
//                     loaded, so the word completed by this load is visible
//                     in the same cycle
//   word_full       : this load fills the final slot of the word
// -----------------------------------------------------------------------------
module vga_pxl_packer
    import vga_mem_pkg::*;
#(
    parameter int RAM_WIDTH = VGA_RAM_WIDTH,
    parameter int PXL_WIDTH = VGA_PXL_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rstn_in,
    input  logic                 clear,
    input  logic                 load,
    input  logic [PXL_WIDTH-1:0] pxl_data,
    output logic [RAM_WIDTH-1:0] packed_word,
    output logic                 word_full
);

    localparam int PPW   = RAM_WIDTH / PXL_WIDTH;
    localparam int CNT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PPW - 1);

    logic [CNT_W-1:0] count_reg;

    // Count wraps on the completing load, so the next word starts at slot 0
    // without the FSM having to clear it explicitly.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= (count_reg == CNT_LAST) ? '0 : count_reg + 1'b1;
        end
    end

    assign word_full = load && (count_reg == CNT_LAST);

    generate
        for (genvar gi = 0; gi < PPW; gi++) begin : g_slot
            logic [PXL_WIDTH-1:0] slot_reg;

            always_ff @(posedge clk_in or negedge rstn_in) begin
                if (!rstn_in) begin
                    slot_reg <= '0;
                end else if (clear) begin
                    slot_reg <= '0;
                end else if (load && (count_reg == CNT_W'(gi))) begin
                    slot_reg <= pxl_data;
                end
            end

            // Bypass the slot being written so the final pixel needs no extra cycle.
            assign packed_word[gi*PXL_WIDTH +: PXL_WIDTH] =
                (count_reg == CNT_W'(gi)) ? pxl_data : slot_reg;
        end
    endgenerate

endmodule

// File: rtl/vga_mem_writer.sv
// -----------------------------------------------------------------------------
// vga_mem_writer
// Write-side controller for the VGA frame memory. Packs PXLS_PER_WORD pixels
// per word and writes words to addresses 0..RAM_DEPTH-1, then pulses done.
// Ports:
//   clk_in, rstn_in  : clock, asynchronous active-low reset
//   start_in         : pulse; starts or restarts a frame fill at address 0
//   clear_in         : (VGA_MEM_WRITER_CLEAR_EN only) zero the whole memory
//   pxl_data_in, pxl_valid_in, pxl_ready_out : pixel stream handshake
//   addr_out, we_out, data_out : memory write port (we_out qualifies)
//   busy_out         : high whenever the FSM is not IDLE
//   done_out         : one-cycle pulse after the final word is written
// Optional build macro: VGA_MEM_WRITER_CLEAR_EN adds clear_in and the CLEAR
// state. All outputs are registered.
// -----------------------------------------------------------------------------
module vga_mem_writer
    import vga_mem_pkg::*;
#(
    parameter int RAM_WIDTH = VGA_RAM_WIDTH,
    parameter int RAM_DEPTH = VGA_RAM_DEPTH,
    parameter int PXL_WIDTH = VGA_PXL_WIDTH
) (
    input  logic                         clk_in,
    input  logic                         rstn_in,
    input  logic                         start_in,
`ifdef VGA_MEM_WRITER_CLEAR_EN
    input  logic                         clear_in,
`endif
    input  logic [PXL_WIDTH-1:0]         pxl_data_in,
    input  logic                         pxl_valid_in,
    output logic                         pxl_ready_out,
    output logic [$clog2(RAM_DEPTH)-1:0] addr_out,
    output logic                         we_out,
    output logic [RAM_WIDTH-1:0]         data_out,
    output logic                         busy_out,
    output logic                         done_out
);

    localparam int ADDR_W = $clog2(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RAM_DEPTH - 1);

    generate
        if (RAM_WIDTH % PXL_WIDTH != 0) begin : g_width_check
            $error("vga_mem_writer: RAM_WIDTH must be a multiple of PXL_WIDTH");
        end
    endgenerate

    vga_mem_wr_state_t    state_reg;
    logic                 ready_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic                 we_reg;
    logic [RAM_WIDTH-1:0] data_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic                 pack_load;
    logic                 pack_full;
    logic [RAM_WIDTH-1:0] pack_word;

    // ready_reg is only ever high in FILL, so it doubles as the state qualifier.
    // start_in wins over a coincident pixel: that pixel is dropped.
    assign pack_load = pxl_valid_in && ready_reg && !start_in;

    vga_pxl_packer #(
        .RAM_WIDTH (RAM_WIDTH),
        .PXL_WIDTH (PXL_WIDTH)
    ) u_packer (
        .clk_in      (clk_in),
        .rstn_in     (rstn_in),
        .clear       (start_in),
        .load        (pack_load),
        .pxl_data    (pxl_data_in),
        .packed_word (pack_word),
        .word_full   (pack_full)
    );

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            data_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            we_reg   <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
`ifdef VGA_MEM_WRITER_CLEAR_EN
                    if (clear_in) begin
                        state_reg <= CLEAR;
                        addr_reg  <= '0;
                        we_reg    <= 1'b1;
                        data_reg  <= '0;
                        busy_reg  <= 1'b1;
                    end else if (start_in) begin
                        state_reg <= FILL;
                        addr_reg  <= '0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
`else
                    if (start_in) begin
                        state_reg <= FILL;
                        addr_reg  <= '0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
`endif
                end

                FILL: begin
                    if (start_in) begin
                        addr_reg <= '0;
                    end else if (pack_full) begin
                        state_reg <= WRITE;
                        we_reg    <= 1'b1;
                        data_reg  <= pack_word;
                        ready_reg <= 1'b0;
                    end
                end

                // The registered write is on the bus during this cycle whatever
                // happens next; a restart only changes where we go afterwards.
                WRITE: begin
                    if (start_in) begin
                        state_reg <= FILL;
                        addr_reg  <= '0;
                        ready_reg <= 1'b1;
                    end else if (addr_reg == ADDR_LAST) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= FILL;
                        addr_reg  <= addr_reg + 1'b1;
                        ready_reg <= 1'b1;
                    end
                end

                DONE: begin
                    addr_reg <= '0;
                    if (start_in) begin
                        state_reg <= FILL;
                        ready_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

`ifdef VGA_MEM_WRITER_CLEAR_EN
                // One zero write per cycle; data_reg was zeroed on entry.
                CLEAR: begin
                    if (start_in) begin
                        state_reg <= FILL;
                        addr_reg  <= '0;
                        ready_reg <= 1'b1;
                    end else if (addr_reg == ADDR_LAST) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        addr_reg <= addr_reg + 1'b1;
                        we_reg   <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign pxl_ready_out = ready_reg;
    assign addr_out      = addr_reg;
    assign we_out        = we_reg;
    assign data_out      = data_reg;
    assign busy_out      = busy_reg;
    assign done_out      = done_reg;

endmodule

// File: tb/tb_vga_mem_writer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vga_mem_writer
// Randomized scoreboard bench. The driver works on falling edges and predicts,
// from the pixel stream it offers, which words must be written and on which
// clock edge; a monitor on falling edges pops and compares each write and done.
// -----------------------------------------------------------------------------
module tb_vga_mem_writer;
    import vga_mem_pkg::*;

    localparam int PPW   = VGA_RAM_WIDTH / VGA_PXL_WIDTH;
    localparam int DEPTH = VGA_RAM_DEPTH;
    localparam int AW    = $clog2(DEPTH);

    logic                     clk_in       = 1'b0;
    logic                     rstn_in      = 1'b0;
    logic                     start_in     = 1'b0;
`ifdef VGA_MEM_WRITER_CLEAR_EN
    logic                     clear_in     = 1'b0;
`endif
    logic [VGA_PXL_WIDTH-1:0] pxl_data_in  = '0;
    logic                     pxl_valid_in = 1'b0;
    logic                     pxl_ready_out;
    logic [AW-1:0]            addr_out;
    logic                     we_out;
    logic [VGA_RAM_WIDTH-1:0] data_out;
    logic                     busy_out;
    logic                     done_out;

    vga_mem_writer dut (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .start_in      (start_in),
`ifdef VGA_MEM_WRITER_CLEAR_EN
        .clear_in      (clear_in),
`endif
        .pxl_data_in   (pxl_data_in),
        .pxl_valid_in  (pxl_valid_in),
        .pxl_ready_out (pxl_ready_out),
        .addr_out      (addr_out),
        .we_out        (we_out),
        .data_out      (data_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int                       tag;
        int                       addr;
        logic [VGA_RAM_WIDTH-1:0] data;
    } wr_t;

    wr_t                      exp_q[$];
    int                       done_q[$];
    logic [VGA_PXL_WIDTH-1:0] acc[$];
    int edge_cnt  = 0;
    int word_idx  = 0;
    int clr_addr  = -1;
    int pass_cnt  = 0;
    int total_cnt = 0;

    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string name, input logic [71:0] act, input logic [71:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write and done pulse must match the front of its queue.
    always @(negedge clk_in) begin
        if (rstn_in) begin
            if (we_out) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_write", 72'(we_out), 72'(0));
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    total_cnt++;
                    if (e.tag == edge_cnt && e.addr == int'(addr_out) && e.data === data_out)
                        pass_cnt++;
                    else
                        $display("FAIL write: got edge=%0d addr=%0d data=0x%0h, expected edge=%0d addr=%0d data=0x%0h",
                                 edge_cnt, addr_out, data_out, e.tag, e.addr, e.data);
                end
                check_val("ready_low_in_write", 72'(pxl_ready_out), 72'(0));
            end
            if (done_out) begin
                if (done_q.size() == 0) check_val("unexpected_done", 72'(done_out), 72'(0));
                else check_val("done_edge", 72'(edge_cnt), 72'(done_q.pop_front()));
            end
        end
    end

    // Predict the effect of the coming rising edge from the inputs now applied,
    // then advance to the next falling edge.
    task automatic step();
        int nxt;
        logic [VGA_RAM_WIDTH-1:0] w;
        nxt = edge_cnt + 1;
`ifdef VGA_MEM_WRITER_CLEAR_EN
        if (clear_in) clr_addr = 0;
`endif
        if (start_in) begin
            acc.delete();
            word_idx = 0;
            clr_addr = -1;
            if (done_q.size() > 0 && done_q[$] == nxt) void'(done_q.pop_back());
        end else if (clr_addr >= 0) begin
            if (clr_addr < DEPTH) begin
                exp_q.push_back('{tag: nxt, addr: clr_addr, data: '0});
                clr_addr++;
            end else begin
                done_q.push_back(nxt);
                clr_addr = -1;
            end
        end else if (pxl_valid_in && pxl_ready_out) begin
            acc.push_back(pxl_data_in);
            if (acc.size() == PPW) begin
                w = '0;
                for (int k = 0; k < PPW; k++)
                    w = w | (VGA_RAM_WIDTH'(acc[k]) << (k * VGA_PXL_WIDTH));
                exp_q.push_back('{tag: nxt, addr: word_idx, data: w});
                if (word_idx == DEPTH - 1) done_q.push_back(nxt + 1);
                word_idx++;
                acc.delete();
            end
        end
        @(negedge clk_in);
    endtask

    task automatic send_pixel(input logic [VGA_PXL_WIDTH-1:0] v);
        int guard;
        guard = 0;
        pxl_valid_in = 1'b1;
        pxl_data_in  = v;
        while (!pxl_ready_out && guard < 50) begin
            step();
            guard++;
        end
        if (!pxl_ready_out) check_val("ready_timeout", 72'(pxl_ready_out), 72'(1));
        else step();
        pxl_valid_in = 1'b0;
        pxl_data_in  = VGA_PXL_WIDTH'($urandom);
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then idle with a pixel offered and no start.
        repeat (3) @(negedge clk_in);
        check_val("rst_ready", 72'(pxl_ready_out), 72'(0));
        check_val("rst_addr",  72'(addr_out),      72'(0));
        check_val("rst_we",    72'(we_out),        72'(0));
        check_val("rst_data",  72'(data_out),      72'(0));
        check_val("rst_busy",  72'(busy_out),      72'(0));
        check_val("rst_done",  72'(done_out),      72'(0));
        rstn_in      = 1'b1;
        pxl_valid_in = 1'b1;
        pxl_data_in  = 12'h123;
        repeat (5) step();
        check_val("idle_ready", 72'(pxl_ready_out), 72'(0));
        check_val("idle_busy",  72'(busy_out),      72'(0));
        pxl_valid_in = 1'b0;

        // Single word 0x001..0x006.
        pulse_start();
        check_val("fill_busy", 72'(busy_out), 72'(1));
        for (int i = 1; i <= PPW; i++) send_pixel(VGA_PXL_WIDTH'(i));
        step();
        check_val("ready_after_write", 72'(pxl_ready_out), 72'(1));

        // Full frame with random valid gaps; restart from the partial state.
        pulse_start();
        for (int i = 0; i < DEPTH * PPW; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
            send_pixel(VGA_PXL_WIDTH'(i % 4096));
        end
        step();
        step();
        check_val("frame_busy_end",  72'(busy_out),      72'(0));
        check_val("frame_ready_end", 72'(pxl_ready_out), 72'(0));
        check_val("frame_writes_left", 72'(exp_q.size()),  72'(0));
        check_val("frame_done_left",   72'(done_q.size()), 72'(0));

`ifdef VGA_MEM_WRITER_CLEAR_EN
        // Full clear from IDLE, then a clear aborted by start.
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        repeat (DEPTH + 1) step();
        check_val("clear_busy_end", 72'(busy_out),     72'(0));
        check_val("clear_left",     72'(done_q.size()), 72'(0));
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        repeat (99) step();
        pulse_start();
        for (int i = 0; i < PPW; i++) send_pixel(VGA_PXL_WIDTH'($urandom));
        step();
        check_val("clear_abort_left", 72'(exp_q.size()), 72'(0));
`endif

        // Second frame, restart coincident with the final write.
        pulse_start();
        for (int i = 0; i < DEPTH * PPW; i++) send_pixel(VGA_PXL_WIDTH'($urandom));
        check_val("last_write_visible", 72'(we_out), 72'(1));
        pulse_start();
        for (int i = 0; i < PPW; i++) send_pixel(VGA_PXL_WIDTH'($urandom));
        repeat (3) step();
        check_val("restart_writes_left", 72'(exp_q.size()), 72'(0));
        check_val("restart_busy", 72'(busy_out), 72'(1));

        // Mid-word restart; the pixel offered with start is dropped.
        for (int i = 0; i < 3; i++) send_pixel(VGA_PXL_WIDTH'($urandom));
        pxl_valid_in = 1'b1;
        pxl_data_in  = 12'h555;
        pulse_start();
        pxl_valid_in = 1'b0;
        for (int i = 0; i < PPW; i++) send_pixel(12'hAAA);
        step();
        check_val("midword_writes_left", 72'(exp_q.size()), 72'(0));

        // Asynchronous reset while a write is on the bus.
        for (int i = 0; i < PPW; i++) send_pixel(VGA_PXL_WIDTH'($urandom));
        #2;
        rstn_in = 1'b0;
        #1;
        check_val("async_rst_we",    72'(we_out),        72'(0));
        check_val("async_rst_ready", 72'(pxl_ready_out), 72'(0));
        check_val("async_rst_addr",  72'(addr_out),      72'(0));
        check_val("async_rst_data",  72'(data_out),      72'(0));
        check_val("async_rst_busy",  72'(busy_out),      72'(0));
        check_val("final_writes_left", 72'(exp_q.size()),  72'(0));
        check_val("final_done_left",   72'(done_q.size()), 72'(0));
        acc.delete();
        word_idx = 0;
        @(negedge clk_in);
        rstn_in = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
